// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver.
//   Frame: start bit (0), Data_width data bits LSB first, optional parity
//   bit, one stop bit (1). Each bit is Prescale CLK cycles long and is
//   decided by a 2-of-3 majority vote around the bit centre.
// Ports:
//   CLK, RST      receiver clock, synchronous active-high reset
//   RX_IN         serial line (idle high, asynchronous to CLK)
//   PAR_EN        frame carries a parity bit
//   PAR_TYP       0 = even parity, 1 = odd parity
//   Prescale      CLK cycles per bit (8, 16 or 32)
//   P_DATA        last correctly received word
//   Data_Valid    one-cycle pulse, P_DATA updated
//   PAR_ERR       one-cycle pulse, parity mismatch
//   STP_ERR       one-cycle pulse, stop bit sampled low
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronized line
// START  | inside the start bit, validating it at the bit centre
// DATA   | shifting in data bits, LSB first
// PARITY | sampling and checking the parity bit
// STOP   | sampling the stop bit, frame verdict on its last cycle
module uart_rx #(
    parameter int Data_width     = 8,
    parameter int Prescale_width = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [Prescale_width-1:0] Prescale,
    output logic [Data_width-1:0]     P_DATA,
    output logic                      Data_Valid,
    output logic                      PAR_ERR,
    output logic                      STP_ERR
);

    localparam int BW = (Data_width > 1) ? $clog2(Data_width) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(Data_width - 1);
    localparam logic [BW-1:0] BIT_ONE = BW'(1);
    localparam logic [Prescale_width-1:0] ONE = Prescale_width'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                    state_q, state_d;
    logic                      sync1_q, sync1_d;
    logic                      rx_s_q, rx_s_d;
    logic                      rx_d_q, rx_d_d;
    logic [Prescale_width-1:0] edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
    logic [Prescale_width-1:0] pre_q, pre_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic                      s0_q, s0_d;
    logic                      s1_q, s1_d;
    logic                      stop_bit_q, stop_bit_d;
    logic                      par_fail_q, par_fail_d;
    logic [Data_width-1:0]     shift_q, shift_d;
    logic [Data_width-1:0]     p_data_q, p_data_d;
    logic                      data_valid_q, data_valid_d;
    logic                      par_err_q, par_err_d;
    logic                      stp_err_q, stp_err_d;

    logic [Prescale_width-1:0] half;
    logic                      last_edge;
    logic                      is_s0;
    logic                      is_s1;
    logic                      is_s2;
    logic                      maj;

    always_comb begin
        sync1_d      = RX_IN;
        rx_s_d       = sync1_q;
        rx_d_d       = rx_s_q;
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        pre_d        = pre_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        s0_d         = s0_q;
        s1_d         = s1_q;
        stop_bit_d   = stop_bit_q;
        par_fail_d   = par_fail_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        half      = pre_q >> 1;
        last_edge = (edge_cnt_q == pre_q - ONE);
        is_s0     = (edge_cnt_q == half - ONE);
        is_s1     = (edge_cnt_q == half);
        is_s2     = (edge_cnt_q == half + ONE);
        // Third vote is the live line value, so the decision lands at P/2+1.
        maj       = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);

        if (state_q != S_IDLE) begin
            edge_cnt_d = last_edge ? '0 : edge_cnt_q + ONE;
            if (is_s0) s0_d = rx_s_q;
            if (is_s1) s1_d = rx_s_q;
        end

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                // Requires a high-to-low transition, so a held-low line never starts a frame.
                if (rx_d_q && !rx_s_q) begin
                    state_d    = S_START;
                    edge_cnt_d = ONE;
                    pre_d      = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_fail_d = 1'b0;
                end
            end
            S_START: begin
                if (is_s2 && maj) begin
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                end else if (last_edge) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (is_s2) shift_d = {maj, shift_q[Data_width-1:1]};
                if (last_edge) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
            end
            S_PARITY: begin
                if (is_s2) par_fail_d = maj ^ (^shift_q) ^ par_typ_q;
                if (last_edge) state_d = S_STOP;
            end
            S_STOP: begin
                if (is_s2) stop_bit_d = maj;
                if (last_edge) begin
                    state_d   = S_IDLE;
                    stp_err_d = ~stop_bit_q;
                    par_err_d = par_fail_q;
                    if (stop_bit_q && !par_fail_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_d_q       <= 1'b1;
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            pre_q        <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            s0_q         <= 1'b0;
            s1_q         <= 1'b0;
            stop_bit_q   <= 1'b0;
            par_fail_q   <= 1'b0;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            rx_s_q       <= rx_s_d;
            rx_d_q       <= rx_d_d;
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            pre_q        <= pre_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            stop_bit_q   <= stop_bit_d;
            par_fail_q   <= par_fail_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames for uart_rx. A negedge monitor
// logs every output pulse with its cycle number; after each frame (or group
// of back-to-back frames) the log is compared with what the frame rules
// predict: pulse kinds, timing from the falling edge of RX_IN, and data.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_ERR;
    logic       STP_ERR;

    uart_rx #(.Data_width(8), .Prescale_width(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_pdata = 8'h00;

    int         dv_cyc[$];
    logic [7:0] dv_dat[$];
    int         pe_cyc[$];
    int         se_cyc[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (Data_Valid) begin
            dv_cyc.push_back(cyc);
            dv_dat.push_back(P_DATA);
        end
        if (PAR_ERR) pe_cyc.push_back(cyc);
        if (STP_ERR) se_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int pick_p();
        case ($urandom_range(0, 2))
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Drives one frame starting at the current negedge. glitch_bit (1..8)
    // flips one cycle at the centre of that data bit. abort_bits > 0 pulses
    // RST after that many bits and returns the line to idle.
    task automatic send_frame(input logic [7:0] data, input int p, input bit pen,
                              input bit ptyp, input bit flip_par, input bit stop_v,
                              input int glitch_bit, input int abort_bits, output int c0);
        bit bits[$];
        bit aborted;
        bit par_bit;
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(data[k]);
        par_bit = bit'($countones(data) % 2) ^ ptyp ^ flip_par;
        if (pen) bits.push_back(par_bit);
        bits.push_back(stop_v);
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        c0       = cyc;
        aborted  = 1'b0;
        for (int i = 0; i < bits.size() && !aborted; i++) begin
            if (abort_bits > 0 && i == abort_bits) begin
                RST = 1'b1;
                @(negedge CLK);
                RST   = 1'b0;
                RX_IN = 1'b1;
                aborted = 1'b1;
                chk("rst_mid_p_data", P_DATA, 0);
                chk("rst_mid_dv", Data_Valid, 0);
                chk("rst_mid_errs", {PAR_ERR, STP_ERR}, 0);
            end else begin
                for (int j = 0; j < p; j++) begin
                    if (i >= 1 && j == 0) begin
                        // configuration must already be latched by now
                        Prescale = 6'(pick_p());
                        PAR_EN   = 1'($urandom_range(0, 1));
                        PAR_TYP  = 1'($urandom_range(0, 1));
                    end
                    RX_IN = (i == glitch_bit && j == p / 2) ? ~bits[i] : bits[i];
                    @(negedge CLK);
                end
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] data, input int p,
                               input bit pen, input bit ptyp, input bit flip_par,
                               input bit stop_v, input int c0);
        int n;
        int lat;
        bit exp_par;
        bit sent_par;
        bit exp_pe;
        bit exp_se;
        n        = 10 + (pen ? 1 : 0);
        lat      = n * p + 1;
        exp_par  = bit'($countones(data) % 2) ^ ptyp;
        sent_par = exp_par ^ flip_par;
        exp_pe   = pen && (sent_par != exp_par);
        exp_se   = !stop_v;
        if (!exp_pe && !exp_se) begin
            chk({tag, "_dv_seen"}, dv_cyc.size() > 0, 1);
            if (dv_cyc.size() > 0) begin
                chk({tag, "_dv_latency"}, dv_cyc.pop_front() - (c0 + 1), lat);
                chk({tag, "_dv_data"}, dv_dat.pop_front(), data);
            end
            exp_pdata = data;
        end
        if (exp_pe) begin
            chk({tag, "_pe_seen"}, pe_cyc.size() > 0, 1);
            if (pe_cyc.size() > 0) chk({tag, "_pe_latency"}, pe_cyc.pop_front() - (c0 + 1), lat);
        end
        if (exp_se) begin
            chk({tag, "_se_seen"}, se_cyc.size() > 0, 1);
            if (se_cyc.size() > 0) chk({tag, "_se_latency"}, se_cyc.pop_front() - (c0 + 1), lat);
        end
    endtask

    task automatic end_group(input string tag);
        chk({tag, "_extra_pulses"}, dv_cyc.size() + pe_cyc.size() + se_cyc.size(), 0);
        chk({tag, "_p_data"}, P_DATA, exp_pdata);
        dv_cyc.delete();
        dv_dat.delete();
        pe_cyc.delete();
        se_cyc.delete();
    endtask

    initial begin
        int c0;
        int c1;
        logic [7:0] d;
        int p;
        bit pen, ptyp, flip, stp;
        int gb;

        RST      = 1'b1;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        Prescale = 6'd8;
        repeat (3) @(negedge CLK);
        chk("reset_p_data", P_DATA, 0);
        chk("reset_dv", Data_Valid, 0);
        chk("reset_par_err", PAR_ERR, 0);
        chk("reset_stp_err", STP_ERR, 0);
        RST = 1'b0;
        idle(5);
        end_group("reset");

        send_frame(8'hA5, 8, 0, 0, 0, 1, 0, 0, c0);
        idle(8);
        check_frame("p8_a5", 8'hA5, 8, 0, 0, 0, 1, c0);
        end_group("p8_a5");

        send_frame(8'h5A, 16, 1, 0, 0, 1, 0, 0, c0);
        idle(8);
        check_frame("p16_even", 8'h5A, 16, 1, 0, 0, 1, c0);
        end_group("p16_even");

        send_frame(8'h5A, 16, 1, 1, 0, 1, 0, 0, c0);
        idle(8);
        check_frame("p16_odd", 8'h5A, 16, 1, 1, 0, 1, c0);
        end_group("p16_odd");

        send_frame(8'h3C, 16, 0, 0, 0, 1, 0, 0, c0);
        idle(8);
        check_frame("p16_3c", 8'h3C, 16, 0, 0, 0, 1, c0);
        end_group("p16_3c");

        send_frame(8'h5A, 16, 1, 0, 1, 1, 0, 0, c0);
        idle(8);
        check_frame("par_err", 8'h5A, 16, 1, 0, 1, 1, c0);
        end_group("par_err");

        send_frame(8'h3C, 8, 0, 0, 0, 0, 0, 0, c0);
        RX_IN = 1'b0;
        repeat (40) @(negedge CLK);
        idle(30);
        check_frame("break", 8'h3C, 8, 0, 0, 0, 0, c0);
        end_group("break");

        send_frame(8'h81, 8, 0, 0, 0, 1, 0, 0, c0);
        idle(8);
        check_frame("after_break", 8'h81, 8, 0, 0, 0, 1, c0);
        end_group("after_break");

        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (2) @(negedge CLK);
        idle(30);
        end_group("start_glitch");

        send_frame(8'h96, 8, 0, 0, 0, 1, 3, 0, c0);
        idle(8);
        check_frame("data_glitch", 8'h96, 8, 0, 0, 0, 1, c0);
        end_group("data_glitch");

        send_frame(8'h01, 32, 0, 0, 0, 1, 0, 0, c0);
        send_frame(8'hFE, 32, 0, 0, 0, 1, 0, 0, c1);
        idle(8);
        chk("b2b_spacing", c1 - c0, 320);
        check_frame("b2b_first", 8'h01, 32, 0, 0, 0, 1, c0);
        check_frame("b2b_second", 8'hFE, 32, 0, 0, 0, 1, c1);
        end_group("b2b");

        send_frame(8'h77, 32, 0, 0, 0, 1, 0, 4, c0);
        exp_pdata = 8'h00;
        idle(400);
        end_group("abort");

        send_frame(8'hC3, 32, 0, 0, 0, 1, 0, 0, c0);
        idle(8);
        check_frame("after_rst", 8'hC3, 32, 0, 0, 0, 1, c0);
        end_group("after_rst");

        for (int k = 0; k < 16; k++) begin
            d    = 8'($urandom_range(0, 255));
            p    = pick_p();
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            flip = ($urandom_range(0, 3) == 0);
            stp  = ($urandom_range(0, 7) != 0);
            gb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
            send_frame(d, p, pen, ptyp, flip, stp, gb, 0, c0);
            idle(6 + int'($urandom_range(0, 10)));
            check_frame("rand", d, p, pen, ptyp, flip, stp, c0);
            end_group("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the downstream counterpart of the system's UART transmitter. It consumes the serial line (TX_OUT of the peer transmitter) and recovers parallel words.
- Frame format: start bit (0), Data_width data bits LSB first, optional parity bit, one stop bit (1).
- Oversampled by CLK with a run-time Prescale. Output feeds the register-file/system-control path via a single-cycle valid pulse.

Parameters:
- Data_width, 8, number of data bits per frame.
- Prescale_width, 6, width of the Prescale port.

Ports:
- CLK  in  1  receiver clock; Prescale CLK cycles per bit.
- RST  in  1  synchronous, active-high reset.
- RX_IN  in  1  serial line, idle high; asynchronous to CLK.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- Prescale  in  Prescale_width  oversampling ratio; legal values 8, 16, 32.
- P_DATA  out  Data_width  last correctly received word.
- Data_Valid  out  1  one-cycle pulse: P_DATA updated.
- PAR_ERR  out  1  one-cycle pulse: parity mismatch.
- STP_ERR  out  1  one-cycle pulse: stop bit sampled 0.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - P_DATA=0; Data_Valid=0; PAR_ERR=0; STP_ERR=0.
  - State=IDLE; all counters 0.
  - Synchronizer flops and the edge-detect flop are set to 1.
  - Reset mid-frame aborts the frame with no pulses.
- Input path:
  - RX_IN passes through a 2-flop synchronizer to give rx_s.
  - rx_d is rx_s delayed by one cycle.
  - All timing below refers to rx_s, which lags RX_IN by 2 CLK.
- Configuration capture: PAR_EN, PAR_TYP and Prescale are latched in the start-detect cycle and held for the whole frame.
- Counters:
  - edge_cnt runs 0..P-1 within each bit; it wraps to 0 at P-1 and advances the bit.
  - bit_cnt counts data bits 0..Data_width-1.
- Sampling:
  - Each bit is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the 2-of-3 majority.
  - The decision is registered at edge_cnt = P/2+1.
- FSM:
  - IDLE: a falling edge (rx_d=1, rx_s=0) moves to START; that cycle counts as edge_cnt=0 of the start bit. A line held low (break) is never a start.
  - START:
    - Majority sample = 1: glitch; return to IDLE at the P/2+1 sample cycle with no outputs.
    - Otherwise at edge P-1 go to DATA.
  - DATA:
    - Bits are shifted LSB-first into an internal shift register.
    - After bit Data_width-1 ends, go to PARITY if PAR_EN=1, else go to STOP.
  - PARITY:
    - Expected parity bit = XOR of the data bits, XOR PAR_TYP.
    - A mismatch sets an internal par_fail flag.
    - At edge P-1 go to STOP.
  - STOP:
    - At edge P-1 evaluate the frame and go to IDLE.
    - All output pulses for the frame fire in this same cycle.
- Frame evaluation (STOP, edge P-1):
  - Stop sample 0: STP_ERR=1.
  - par_fail=1: PAR_ERR=1. Both errors may pulse in the same cycle.
  - No error: P_DATA is loaded from the shift register and Data_Valid=1.
  - Any error: Data_Valid stays 0 and P_DATA retains its previous value.
- Latency: pulses occur exactly (2+Data_width+PAR_EN)*P - 1 CLK after the start-detect cycle.
- Back-to-back frames: a start bit immediately following the stop bit is caught. The line is high during the stop bit, so rx_d=1 on the first low cycle.
- Error flags are pulses, not sticky. No flow control: a new frame overwrites P_DATA regardless of the consumer.
- Illegal Prescale (not 8/16/32): behaviour unspecified and not verified.

Test Plan:
- P=8, PAR_EN=0, send 0xA5 → Data_Valid pulses once, 79 CLK after start detect (81 after RX_IN falls); P_DATA=0xA5; no error pulses.
- P=16, PAR_EN=1, PAR_TYP=0, send 0x5A with parity bit 0 → P_DATA=0x5A, Data_Valid pulse at 175 CLK after detect. Repeat with PAR_TYP=1 and parity bit 1 → same result.
- P=16, even parity, send 0x5A with parity bit 1 → PAR_ERR pulses one cycle; Data_Valid=0; P_DATA unchanged from the prior value.
- P=8, send 0x3C with stop bit 0, then hold the line low for 40 CLK → STP_ERR pulses once; no new start is detected until the line returns high and falls again.
- P=8, 2-cycle low glitch on the idle line → no pulses; FSM back in IDLE by detect+5. Also, a single-cycle low during a data-bit sample window is masked by majority voting.
- P=32, back-to-back frames 0x01 then 0xFE with no idle gap → two Data_Valid pulses 320 CLK apart with correct data. Assert RST mid-way through a third frame → outputs 0 next cycle; a clean frame after reset is received correctly.
